// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator. Each channel counts down from its
// period and emits a one-cycle tick on expiry, either periodically or once.
module tick_gen_multi #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 4,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q  [NCH];
  state_e           state_d  [NCH];
  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] period_d [NCH];
  logic [WIDTH-1:0] count_q  [NCH];
  logic [WIDTH-1:0] count_d  [NCH];
  logic             mode_q   [NCH];
  logic             mode_d   [NCH];
  logic             tick_q   [NCH];
  logic             tick_d   [NCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= StIdle;
        period_q[i] <= '0;
        count_q[i]  <= '0;
        mode_q[i]   <= 1'b0;
        tick_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        count_q[i]  <= count_d[i];
        mode_q[i]   <= mode_d[i];
        tick_q[i]   <= tick_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      logic hit;
      logic step;
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      mode_d[i]   = mode_q[i];
      tick_d[i]   = 1'b0;
      // Out-of-range cfg_ch never matches any i, so such writes are dropped.
      hit  = cfg_we && (cfg_ch == CHW'(i));
      step = (state_q[i] == StRun) && en && !(hit && (cfg_start || cfg_stop));
      if (hit) begin
        period_d[i] = cfg_period;
        mode_d[i]   = cfg_oneshot;
        if (cfg_stop) begin
          state_d[i] = StIdle;
          count_d[i] = '0;
        end else if (cfg_start) begin
          state_d[i] = StRun;
          count_d[i] = cfg_period;
        end
      end
      if (step) begin
        if (count_q[i] == '0) begin
          // Reload from the pre-write period so a same-cycle plain write waits.
          tick_d[i]  = 1'b1;
          count_d[i] = period_q[i];
          if (mode_q[i]) state_d[i] = StDone;
        end else begin
          count_d[i] = count_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tick[i] = tick_q[i];
      busy[i] = (state_q[i] == StRun);
      done[i] = (state_q[i] == StDone);
    end
  end

endmodule
